control_pipe_register: RTL and testbench
========================================

Name: control_pipe_register

Overview:
Parametrised elastic pipeline register for microinstruction words leaving the control store. It carries the full control word plus the current-state tag through DEPTH stages with a valid/ready handshake, stall back-pressure and flush. Idle or flushed slots present a programmable NOP word, so no stray control signal is asserted. The block sits between the control store/next-state logic and the field decode that drives the datapath load, select and op signals.

Parameters:
WORD_W, 39, control word width (field packing owned by the decode stage)
STATE_W, 10, state tag width
DEPTH, 2, number of pipeline stages; legal range 1..4
NOP_WORD, {WORD_W{1'b0}}, word presented on idle or flushed slots
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block accepts the word this cycle
in_word  input  WORD_W  control word from the control store
in_state  input  STATE_W  state number associated with in_word
flush  input  1  discard all in-flight words
out_valid  output  1  last stage holds a valid word
out_ready  input  1  downstream consumes the word this cycle
out_word  output  WORD_W  last-stage word, or NOP_WORD when out_valid=0
out_state  output  STATE_W  last-stage state tag, or 0 when out_valid=0
occupancy  output  3  number of valid stages, 0..DEPTH
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
in_parity  input  1  even parity of in_word (CTRL_PARITY_EN only)
par_err  output  1  sticky parity error (CTRL_PARITY_EN only)

Behaviour:
- Each stage k holds {vld_k, word_k, state_k}. Stage 0 is the input side and stage DEPTH-1 is the output side.
- A stage advances when it is invalid or when its downstream stage advances. The last stage advances when out_ready=1 or when it is invalid.
- in_ready = (!vld_0 || stage 0 advances) && !flush. This is combinational from out_ready through the stage chain, with no registered skid.
- Transfer rule: the input is written only when in_valid && in_ready. Otherwise stage 0 loads vld=0 with word=NOP_WORD while it advances.
- Latency is DEPTH cycles from acceptance to out_valid with no stalls. Throughput is 1 word/cycle sustained.
- Back-pressure: while out_ready=0, every valid stage holds word and state unchanged. Bubbles collapse, so invalid stages still advance and fill.
- Simultaneous input and output transfer in the same cycle with a full pipe is legal. Occupancy stays at DEPTH.
- occupancy is the count of set vld_k bits, registered with the stages. It never exceeds DEPTH.
- flush, next edge:
  - all vld_k=0, all word_k=NOP_WORD, state_k=0
  - the input in that cycle is not accepted (in_ready=0)
  - stall_cnt is not affected
- flush and reset asserted together: reset dominates (identical effect, plus counters are cleared).
- stall_cnt increments each cycle with out_valid && !out_ready. It saturates at 2^CNT_W-1 and clears only on reset.
- reset, next edge: all vld_k=0, words=NOP_WORD, states=0, occupancy=0, stall_cnt=0, par_err=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_word=NOP_WORD, out_state=0.
  - Reset mid-transfer drops all in-flight words with no partial output.
- DEPTH outside 1..4 is an elaboration error.

Optional Feature:
CTRL_PARITY_EN:
- Defined:
  - in_parity and par_err ports exist.
  - A parity bit travels with each word through every stage.
  - When a word leaves the last stage (out_valid && out_ready) and ^{word, parity} != 0, par_err sets on the next edge and holds until reset. The word is still delivered.
  - Flushed or NOP slots are never checked.
- Undefined: the ports, parity storage and check logic are absent.

Test Plan:
- Reset, then stream words 0x1,0x2,0x3 with out_ready=1, DEPTH=2 -> out_valid first at cycle 2 after acceptance; out_word sequence 0x1,0x2,0x3; in_ready stays 1.
- Fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0 after the pipe fills (occupancy=2), stall_cnt=5, out_word stable; release -> words exit in order with no loss or duplication.
- Pipe full, assert flush for one cycle with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_word=NOP_WORD; the flushed-cycle input is not accepted.
- Assert reset mid-stream with occupancy=2 and stall_cnt nonzero -> next cycle all outputs at reset values, stall_cnt=0.
- Force stall_cnt near max (CNT_W=4, 20 stall cycles) -> stall_cnt holds at 15.
- CTRL_PARITY_EN: send word 0x3 with in_parity=1 (bad) -> par_err=1 one cycle after the word is consumed; stays 1 through subsequent good words until reset.

Source files
------------

// File: rtl/control_pipe_register.sv
// Elastic DEPTH-stage register for control-store microinstruction words and their state tags.
// Latency: DEPTH cycles from acceptance to out_valid; sustains 1 word/cycle.
// Backpressure: in_ready is combinational from out_ready; bubbles collapse; optional parity via CTRL_PARITY_EN.
module control_pipe_register #(
    parameter int                WORD_W   = 39,
    parameter int                STATE_W  = 10,
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] NOP_WORD = {WORD_W{1'b0}},
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    input  logic [STATE_W-1:0] in_state,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_word,
    output logic [STATE_W-1:0] out_state,
    output logic [2:0]         occupancy,
`ifdef CTRL_PARITY_EN
    input  logic               in_parity,
    output logic               par_err,
`endif
    output logic [CNT_W-1:0]   stall_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("control_pipe_register: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]   vld_q, vld_nxt, adv;
    logic [WORD_W-1:0]  word_q  [DEPTH];
    logic [WORD_W-1:0]  word_nxt[DEPTH];
    logic [STATE_W-1:0] state_q  [DEPTH];
    logic [STATE_W-1:0] state_nxt[DEPTH];
    logic [2:0]         occ_nxt;
    logic               in_xfer;
`ifdef CTRL_PARITY_EN
    logic [DEPTH-1:0]   par_q, par_nxt;
`endif

    // A stage advances when out_ready is high or any stage at or beyond it is empty.
    always_comb begin
        adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!vld_q[j]) adv[k] = 1'b1;
            end
        end
    end

    assign in_ready = adv[0] && !flush;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        vld_nxt   = vld_q;
        word_nxt  = word_q;
        state_nxt = state_q;
`ifdef CTRL_PARITY_EN
        par_nxt   = par_q;
`endif
        for (int k = DEPTH-1; k >= 1; k--) begin
            if (adv[k]) begin
                vld_nxt[k]   = vld_q[k-1];
                word_nxt[k]  = vld_q[k-1] ? word_q[k-1] : NOP_WORD;
                state_nxt[k] = vld_q[k-1] ? state_q[k-1] : '0;
`ifdef CTRL_PARITY_EN
                par_nxt[k]   = vld_q[k-1] && par_q[k-1];
`endif
            end
        end
        if (adv[0]) begin
            vld_nxt[0]   = in_xfer;
            word_nxt[0]  = in_xfer ? in_word : NOP_WORD;
            state_nxt[0] = in_xfer ? in_state : '0;
`ifdef CTRL_PARITY_EN
            par_nxt[0]   = in_xfer && in_parity;
`endif
        end
        if (flush) begin
            vld_nxt = '0;
            for (int k = 0; k < DEPTH; k++) begin
                word_nxt[k]  = NOP_WORD;
                state_nxt[k] = '0;
            end
`ifdef CTRL_PARITY_EN
            par_nxt = '0;
`endif
        end
        occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt = occ_nxt + 3'(vld_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= '0;
            occupancy <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                word_q[k]  <= NOP_WORD;
                state_q[k] <= '0;
            end
        end else begin
            vld_q     <= vld_nxt;
            occupancy <= occ_nxt;
            word_q    <= word_nxt;
            state_q   <= state_nxt;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_word  = out_valid ? word_q[DEPTH-1] : NOP_WORD;
    assign out_state = out_valid ? state_q[DEPTH-1] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

`ifdef CTRL_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q   <= '0;
            par_err <= 1'b0;
        end else begin
            par_q <= par_nxt;
            // The word is delivered regardless; the error is only recorded.
            if (out_valid && out_ready && (^{out_word, par_q[DEPTH-1]})) par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_control_pipe_register.sv
module tb_control_pipe_register;
    localparam int WORD_W  = 39;
    localparam int STATE_W = 10;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [WORD_W-1:0] NOP = 39'h5A_A5C3_3C0F;

    logic               clk = 1'b0;
    logic               reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [WORD_W-1:0]  in_word, out_word;
    logic [STATE_W-1:0] in_state, out_state;
    logic [2:0]         occupancy;
    logic [CNT_W-1:0]   stall_cnt;
`ifdef CTRL_PARITY_EN
    logic               in_parity, par_err;
`endif

    int total = 0;
    int bad   = 0;

    control_pipe_register #(
        .WORD_W(WORD_W), .STATE_W(STATE_W), .DEPTH(DEPTH), .NOP_WORD(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_state(in_state), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_state(out_state), .occupancy(occupancy),
`ifdef CTRL_PARITY_EN
        .in_parity(in_parity), .par_err(par_err),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit fl, input bit iv, input logic [WORD_W-1:0] w,
                         input logic [STATE_W-1:0] s, input bit ordy);
        reset = r; flush = fl; in_valid = iv; in_word = w; in_state = s; out_ready = ordy;
`ifdef CTRL_PARITY_EN
        in_parity = ^w;
`endif
    endtask

    task automatic chk_out(input string tag, input bit ov, input logic [WORD_W-1:0] w,
                           input logic [STATE_W-1:0] s, input int occ, input int st);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, " out_word"},  64'(out_word),  64'(w));
        chk({tag, " out_state"}, 64'(out_state), 64'(s));
        chk({tag, " occupancy"}, 64'(occupancy), 64'(occ));
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(st));
    endtask

    // Directed vectors: inputs for one cycle, in_ready expected during it, outputs after the edge.
    typedef struct {
        bit rst, fl, iv, ordy;
        int x;
        bit e_rdy, e_ov;
        int e_x, e_occ, e_st;
    } vec_t;

    function automatic vec_t mk(bit rst, bit fl, bit iv, int x, bit ordy,
                                bit e_rdy, bit e_ov, int e_x, int e_occ, int e_st);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.x = x; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_x = e_x; v.e_occ = e_occ; v.e_st = e_st;
        return v;
    endfunction

    // Reference model: in-flight words with their stage position; words slide forward
    // until they hit the word ahead of them or the output end.
    typedef struct {
        logic [WORD_W-1:0]  w;
        logic [STATE_W-1:0] s;
        int                 pos;
    } item_t;
    item_t mq[$];
    int    m_stall;

    function automatic bit m_ov();
        return mq.size() > 0 && mq[0].pos == DEPTH-1;
    endfunction

    function automatic bit m_rdy(input bit ordy, input bit fl);
        int lim = DEPTH-1;
        int start;
        if (fl) return 1'b0;
        start = (m_ov() && ordy) ? 1 : 0;
        for (int i = start; i < mq.size(); i++) begin
            int np;
            np  = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
            lim = np - 1;
        end
        return lim >= 0;
    endfunction

    task automatic m_step(input bit r, input bit fl, input bit iv, input logic [WORD_W-1:0] w,
                          input logic [STATE_W-1:0] s, input bit ordy);
        bit ov, rdy;
        int lim;
        item_t it;
        if (r) begin
            mq.delete();
            m_stall = 0;
            return;
        end
        ov  = m_ov();
        rdy = m_rdy(ordy, fl);
        if (ov && !ordy && m_stall < CNT_MAX) m_stall++;
        if (fl) begin
            mq.delete();
            return;
        end
        if (ov && ordy) void'(mq.pop_front());
        lim = DEPTH-1;
        for (int i = 0; i < mq.size(); i++) begin
            int np;
            np = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
            mq[i].pos = np;
            lim = np - 1;
        end
        if (iv && rdy) begin
            it.w = w; it.s = s; it.pos = 0;
            mq.push_back(it);
        end
    endtask

    initial begin
        vec_t tbl[23];
        tbl[0]  = mk(0,0,1,1,1,   1,0,0,1,0);
        tbl[1]  = mk(0,0,1,2,1,   1,1,1,2,0);
        tbl[2]  = mk(0,0,1,3,1,   1,1,2,2,0);
        tbl[3]  = mk(0,0,0,0,1,   1,1,3,1,0);
        tbl[4]  = mk(0,0,0,0,1,   1,0,0,0,0);
        tbl[5]  = mk(0,0,1,4,0,   1,0,0,1,0);
        tbl[6]  = mk(0,0,1,5,0,   1,1,4,2,0);
        tbl[7]  = mk(0,0,1,6,0,   0,1,4,2,1);
        tbl[8]  = mk(0,0,1,6,0,   0,1,4,2,2);
        tbl[9]  = mk(0,0,1,6,0,   0,1,4,2,3);
        tbl[10] = mk(0,0,1,6,0,   0,1,4,2,4);
        tbl[11] = mk(0,0,1,6,0,   0,1,4,2,5);
        tbl[12] = mk(0,0,0,0,1,   1,1,5,1,5);
        tbl[13] = mk(0,0,0,0,1,   1,0,0,0,5);
        tbl[14] = mk(0,0,1,7,0,   1,0,0,1,5);
        tbl[15] = mk(0,0,1,8,0,   1,1,7,2,5);
        tbl[16] = mk(0,1,1,9,0,   0,0,0,0,6);
        tbl[17] = mk(0,0,0,0,1,   1,0,0,0,6);
        tbl[18] = mk(0,0,1,10,0,  1,0,0,1,6);
        tbl[19] = mk(0,0,1,11,0,  1,1,10,2,6);
        tbl[20] = mk(0,0,1,12,0,  0,1,10,2,7);
        tbl[21] = mk(1,1,1,13,0,  0,0,0,0,0);
        tbl[22] = mk(0,0,0,0,0,   1,0,0,0,0);

        drive(1, 0, 0, '0, '0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 1);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk_out("reset", 0, NOP, '0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, WORD_W'(tbl[i].x), STATE_W'(tbl[i].x), tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].e_ov,
                    tbl[i].e_ov ? WORD_W'(tbl[i].e_x) : NOP,
                    tbl[i].e_ov ? STATE_W'(tbl[i].e_x) : '0,
                    tbl[i].e_occ, tbl[i].e_st);
        end

        // Saturation: one word held at the output for 20 stalled cycles.
        @(negedge clk);
        drive(0, 0, 1, WORD_W'(33), STATE_W'(33), 0);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0);
        repeat (21) @(negedge clk);
        chk_out("sat", 1, WORD_W'(33), STATE_W'(33), 1, CNT_MAX);
        drive(0, 0, 0, '0, '0, 1);
        @(negedge clk);
        chk_out("sat release", 0, NOP, '0, 0, CNT_MAX);

`ifdef CTRL_PARITY_EN
        drive(1, 0, 0, '0, '0, 1);
        @(negedge clk);
        chk("par reset", 64'(par_err), 64'd0);
        drive(0, 0, 1, WORD_W'(3), STATE_W'(3), 1);
        in_parity = 1'b1;
        @(negedge clk);
        drive(0, 0, 1, WORD_W'(4), STATE_W'(4), 1);
        @(negedge clk);
        chk("par before exit", 64'(par_err), 64'd0);
        chk("par bad word out", 64'(out_word), 64'd3);
        drive(0, 0, 1, WORD_W'(5), STATE_W'(5), 1);
        @(negedge clk);
        chk("par set", 64'(par_err), 64'd1);
        drive(0, 0, 1, WORD_W'(6), STATE_W'(6), 1);
        repeat (3) @(negedge clk);
        chk("par sticky", 64'(par_err), 64'd1);
        drive(1, 0, 0, '0, '0, 1);
        @(negedge clk);
        chk("par cleared", 64'(par_err), 64'd0);
`endif

        // Randomised run against the reference model.
        @(negedge clk);
        drive(1, 0, 0, '0, '0, 1);
        m_step(1, 0, 0, '0, '0, 1);
        for (int c = 0; c < 1500; c++) begin
            bit r, fl, iv, ordy;
            logic [WORD_W-1:0] w;
            logic [STATE_W-1:0] s;
            @(negedge clk);
            chk_out("rand", m_ov(), m_ov() ? mq[0].w : NOP, m_ov() ? mq[0].s : '0,
                    mq.size(), m_stall);
`ifdef CTRL_PARITY_EN
            chk("rand par_err", 64'(par_err), 64'd0);
`endif
            r    = ($urandom_range(0, 199) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            w    = WORD_W'({$urandom(), $urandom()});
            s    = STATE_W'($urandom());
            drive(r, fl, iv, w, s, ordy);
            #1;
            chk("rand in_ready", 64'(in_ready), 64'(m_rdy(ordy, fl)));
            m_step(r, fl, iv, w, s, ordy);
        end
        @(negedge clk);
        chk_out("rand final", m_ov(), m_ov() ? mq[0].w : NOP, m_ov() ? mq[0].s : '0,
                mq.size(), m_stall);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
